// File: rtl/j_jiotimer_if.sv
// JERRY I/O bus view of the timer bank: word address, active-low strobes,
// write data in, registered read-back data and its output enable.
interface j_jiotimer_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic [AW-1:0] a;
  logic          cs_l;
  logic          we_l;
  logic          oe_l;
  logic [DW-1:0] d_in;
  logic [DW-1:0] dr_out;
  logic          dr_oe;

  modport master (output a, cs_l, we_l, oe_l, d_in, input dr_out, dr_oe);
  modport slave  (input a, cs_l, we_l, oe_l, d_in, output dr_out, dr_oe);
endinterface

// File: rtl/j_jiotimer.sv
// Multi-channel programmable interval timer bank for the JERRY I/O space:
// per-channel prescaler/divider, enables, sticky pending/mask and read-back.
module j_jiotimer #(
  parameter int         NCH  = 4,
  parameter int         AW   = 16,
  parameter int         DW   = 16,
  parameter logic [7:0] BASE = 8'h1A
) (
  input  logic           sys_clk,
  input  logic           resetl,
  j_jiotimer_if.slave    bus,
  output logic [NCH-1:0] tick,
  output logic           int_l
);

  logic           sel;
  logic [7:0]     off;
  logic           wr_req;
  logic           wr_q;
  logic           wr_stb;
  logic           rd_req;
  logic           en_wr;
  logic           pend_wr;
  logic           mask_wr;
  logic [DW-1:0]  pre_r   [NCH];
  logic [DW-1:0]  div_r   [NCH];
  logic [DW-1:0]  pre_cnt [NCH];
  logic [DW-1:0]  div_cnt [NCH];
  logic [NCH-1:0] en;
  logic [NCH-1:0] pend;
  logic [NCH-1:0] mask;
  logic [NCH-1:0] en_next;
  logic [NCH-1:0] clr;
  logic [NCH-1:0] pre_wr;
  logic [NCH-1:0] div_wr;
  logic [NCH-1:0] load;
  logic [DW-1:0]  rd_val;

  assign sel     = ~bus.cs_l & (bus.a[AW-1:8] == (AW-8)'(BASE));
  assign off     = bus.a[7:0];
  // A held write strobe commits only on its first selected cycle
  assign wr_req  = sel & ~bus.we_l;
  assign wr_stb  = wr_req & ~wr_q;
  assign rd_req  = sel & ~bus.oe_l & bus.we_l;
  assign en_wr   = wr_stb & (off == 8'h40);
  assign pend_wr = wr_stb & (off == 8'h41);
  assign mask_wr = wr_stb & (off == 8'h42);
  assign en_next = en_wr ? bus.d_in[NCH-1:0] : en;
  assign clr     = pend_wr ? bus.d_in[NCH-1:0] : '0;

  // A reload (DIV write or enable rising) takes priority over counting and suppresses the tick
  always_comb begin
    pre_wr = '0;
    div_wr = '0;
    load   = '0;
    tick   = '0;
    for (int c = 0; c < NCH; c++) begin
      pre_wr[c] = wr_stb & (off == 8'(4 * c));
      div_wr[c] = wr_stb & (off == 8'(4 * c + 1));
      load[c]   = div_wr[c] | (en_next[c] & ~en[c]);
      tick[c]   = en[c] & ~load[c] & (pre_cnt[c] == '0) & (div_cnt[c] == '0);
    end
  end

  always_comb begin
    rd_val = '0;
    for (int c = 0; c < NCH; c++) begin
      if (off[7:2] == 6'(c)) begin
        case (off[1:0])
          2'd0:    rd_val = pre_r[c];
          2'd1:    rd_val = div_r[c];
          2'd2:    rd_val = pre_cnt[c];
          default: rd_val = div_cnt[c];
        endcase
      end
    end
    case (off)
      8'h40:   rd_val = DW'(en);
      8'h41:   rd_val = DW'(pend);
      8'h42:   rd_val = DW'(mask);
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      wr_q       <= 1'b0;
      en         <= '0;
      pend       <= '0;
      mask       <= '0;
      int_l      <= 1'b1;
      bus.dr_oe  <= 1'b0;
      bus.dr_out <= '0;
    end else begin
      wr_q       <= wr_req;
      en         <= en_next;
      pend       <= (pend & ~clr) | tick;
      if (mask_wr)
        mask <= bus.d_in[NCH-1:0];
      int_l      <= ~|(pend & mask);
      bus.dr_oe  <= rd_req;
      bus.dr_out <= rd_req ? rd_val : '0;
    end
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      for (int c = 0; c < NCH; c++) begin
        pre_r[c]   <= '0;
        div_r[c]   <= '0;
        pre_cnt[c] <= '0;
        div_cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (pre_wr[c])
          pre_r[c] <= bus.d_in;
        if (div_wr[c])
          div_r[c] <= bus.d_in;
        if (load[c]) begin
          pre_cnt[c] <= pre_r[c];
          div_cnt[c] <= div_wr[c] ? bus.d_in : div_r[c];
        end else if (en[c]) begin
          if (pre_cnt[c] != '0) begin
            pre_cnt[c] <= pre_cnt[c] - DW'(1);
          end else begin
            pre_cnt[c] <= pre_r[c];
            div_cnt[c] <= (div_cnt[c] != '0) ? div_cnt[c] - DW'(1) : div_r[c];
          end
        end
      end
    end
  end

endmodule
